// File: rtl/axis_bf_weight_mult.sv
// Beamforming weight stage: multiplies 16 signed 8-bit samples per AXI-Stream beat by one
// signed 8-bit weight. The weight only changes on packet boundaries. Two register stages.
module axis_bf_weight_mult #(
    parameter int SDATA_WIDTH   = 128,
    parameter int SSAMPLE_WIDTH = 8,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int MSAMPLE_WIDTH = 16,
    parameter int MDATA_WIDTH   = 256
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [WEIGHT_WIDTH-1:0]    weight_in,
    input  logic                       weight_load,
    output logic [WEIGHT_WIDTH-1:0]    weight_active,
    input  logic [SDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [MDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [MDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready
);

    localparam int SAMPLES    = SDATA_WIDTH / SSAMPLE_WIDTH;
    localparam int KEEP_WIDTH = MDATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    // Full-precision signed product per lane; operands are sign-extended to product width.
    function automatic logic [MDATA_WIDTH-1:0] mult_lanes(
        input logic [SDATA_WIDTH-1:0]  samples,
        input logic [WEIGHT_WIDTH-1:0] weight
    );
        logic [MDATA_WIDTH-1:0]          result;
        logic signed [MSAMPLE_WIDTH-1:0] a_ext;
        logic signed [MSAMPLE_WIDTH-1:0] w_ext;
        logic signed [MSAMPLE_WIDTH-1:0] prod;
        result = '0;
        w_ext  = {{(MSAMPLE_WIDTH-WEIGHT_WIDTH){weight[WEIGHT_WIDTH-1]}}, weight};
        for (int i = 0; i < SAMPLES; i++) begin
            a_ext = {{(MSAMPLE_WIDTH-SSAMPLE_WIDTH){samples[i*SSAMPLE_WIDTH+SSAMPLE_WIDTH-1]}},
                     samples[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]};
            prod  = a_ext * w_ext;
            result[i*MSAMPLE_WIDTH +: MSAMPLE_WIDTH] = prod;
        end
        return result;
    endfunction

    logic [0:0]              r_state;
    logic                    r_pend_valid;
    logic [WEIGHT_WIDTH-1:0] r_pend_weight;
    logic [WEIGHT_WIDTH-1:0] r_weight_active;

    logic                    r_s1_valid;
    logic [SDATA_WIDTH-1:0]  r_s1_data;
    logic [WEIGHT_WIDTH-1:0] r_s1_weight;
    logic                    r_s1_last;

    logic                    r_m_valid;
    logic [MDATA_WIDTH-1:0]  r_m_data;
    logic [KEEP_WIDTH-1:0]   r_m_keep;
    logic                    r_m_last;

    logic                    w_advance;
    logic                    w_accept;
    logic                    w_apply;
    logic [WEIGHT_WIDTH-1:0] w_beat_weight;

    // Handshake and weight-apply decode; a pending weight is applied only between packets.
    always_comb begin
        w_advance = !r_m_valid || m_axis_tready;
        w_accept  = s_axis_tvalid && w_advance && resetn;
        w_apply   = (r_state == ST_IDLE) && r_pend_valid;
        if (w_apply) begin
            w_beat_weight = r_pend_weight;
        end else begin
            w_beat_weight = r_weight_active;
        end
    end

    // Pending weight, applied weight and packet-boundary state.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state         <= ST_IDLE;
            r_pend_valid    <= 1'b0;
            r_pend_weight   <= {WEIGHT_WIDTH{1'b0}};
            r_weight_active <= {{(WEIGHT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            // A load in the same cycle as an apply becomes the next pending value.
            if (weight_load) begin
                r_pend_valid  <= 1'b1;
                r_pend_weight <= weight_in;
            end else if (w_apply) begin
                r_pend_valid  <= 1'b0;
            end else begin
                r_pend_valid  <= r_pend_valid;
            end
            if (w_apply) begin
                r_weight_active <= r_pend_weight;
            end else begin
                r_weight_active <= r_weight_active;
            end
            if (w_accept) begin
                r_state <= s_axis_tlast ? ST_IDLE : ST_IN_PKT;
            end else begin
                r_state <= r_state;
            end
        end
    end

    // Two-stage data pipeline; every stage holds while the output is stalled.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= {SDATA_WIDTH{1'b0}};
            r_s1_weight <= {WEIGHT_WIDTH{1'b0}};
            r_s1_last   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= {MDATA_WIDTH{1'b0}};
            r_m_keep    <= {KEEP_WIDTH{1'b0}};
            r_m_last    <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid  <= w_accept;
            r_s1_data   <= w_accept ? s_axis_tdata : {SDATA_WIDTH{1'b0}};
            r_s1_weight <= w_beat_weight;
            r_s1_last   <= w_accept && s_axis_tlast;
            r_m_valid   <= r_s1_valid;
            r_m_data    <= r_s1_valid ? mult_lanes(r_s1_data, r_s1_weight) : {MDATA_WIDTH{1'b0}};
            r_m_keep    <= {KEEP_WIDTH{r_s1_valid}};
            r_m_last    <= r_s1_valid && r_s1_last;
        end else begin
            r_s1_valid  <= r_s1_valid;
            r_s1_data   <= r_s1_data;
            r_s1_weight <= r_s1_weight;
            r_s1_last   <= r_s1_last;
            r_m_valid   <= r_m_valid;
            r_m_data    <= r_m_data;
            r_m_keep    <= r_m_keep;
            r_m_last    <= r_m_last;
        end
    end

    assign s_axis_tready = w_advance && resetn;
    assign weight_active = r_weight_active;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tkeep  = r_m_keep;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_m_last;

endmodule

// File: tb/tb_axis_bf_weight_mult.sv
// Self-checking bench for axis_bf_weight_mult: constant vectors, directed corner sequences
// and randomized traffic scored against a transaction-level model.
module tb_axis_bf_weight_mult;

    logic         CLK = 1'b0;
    logic         resetn = 1'b0;
    logic [7:0]   weight_in = 8'h00;
    logic         weight_load = 1'b0;
    logic [7:0]   weight_active;
    logic [127:0] s_axis_tdata = 128'h0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b1;

    axis_bf_weight_mult dut (
        .CLK(CLK), .resetn(resetn),
        .weight_in(weight_in), .weight_load(weight_load), .weight_active(weight_active),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  w;
        logic [7:0]  s;
        logic [15:0] p;
    } vec_t;
    vec_t vecs[8];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction-level model state
    logic [7:0]   md_active = 8'h01;
    logic [7:0]   md_pend = 8'h00;
    bit           md_pend_v = 1'b0;
    bit           md_open = 1'b0;
    logic [255:0] exp_q[$];
    bit           exp_last_q[$];

    bit           rdy_random = 1'b0;
    int           hold_low = 0;
    bit           stall_prev = 1'b0;
    logic [255:0] prev_data;
    logic         prev_last;
    bit           last_acc;
    logic [255:0] last_out = '0;
    int first_acc = -1, first_out = -1, last_out_cyc = -1, out_n = 0, last_cnt = 0, last_idx = 0;

    function automatic logic [255:0] ref_beat(input logic [127:0] s, input logic [7:0] w);
        logic [255:0] r;
        int a, b;
        r = '0;
        b = int'($signed(w));
        for (int i = 0; i < 16; i++) begin
            a = int'($signed(s[i*8 +: 8]));
            r[i*16 +: 16] = 16'(a * b);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // One clock: score outputs at negedge, advance the model, step past the edge.
    task automatic cycle();
        logic [255:0] e;
        bit el;
        if (rdy_random) begin
            if (hold_low > 0) begin
                m_axis_tready = 1'b0;
                hold_low--;
            end else if ($urandom_range(0, 39) == 0) begin
                m_axis_tready = 1'b0;
                hold_low = 4;
            end else begin
                m_axis_tready = ($urandom_range(0, 99) < 65);
            end
        end else begin
            m_axis_tready = 1'b1;
        end
        @(negedge CLK);
        check("s_tready", 256'(s_axis_tready), 256'(!m_axis_tvalid || m_axis_tready));
        if (m_axis_tvalid) begin
            check("tkeep_valid", 256'(m_axis_tkeep), 256'(32'hFFFFFFFF));
            if (stall_prev) begin
                check("stall_data", m_axis_tdata, prev_data);
                check("stall_last", 256'(m_axis_tlast), 256'(prev_last));
            end
            if (m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output_beat");
                end else begin
                    e = exp_q.pop_front();
                    el = exp_last_q.pop_front();
                    check("out_data", m_axis_tdata, e);
                    check("out_last", 256'(m_axis_tlast), 256'(el));
                end
                last_out = m_axis_tdata;
                out_n++;
                if (first_out < 0) first_out = cyc;
                last_out_cyc = cyc;
                if (m_axis_tlast) begin
                    last_cnt++;
                    last_idx = out_n;
                end
            end
        end else begin
            check("idle_data", m_axis_tdata, 256'h0);
            check("idle_keep", 256'(m_axis_tkeep), 256'h0);
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_data = m_axis_tdata;
        prev_last = m_axis_tlast;
        last_acc = s_axis_tvalid && s_axis_tready;
        if (!md_open && md_pend_v) begin
            md_active = md_pend;
            md_pend_v = 1'b0;
        end
        if (last_acc) begin
            exp_q.push_back(ref_beat(s_axis_tdata, md_active));
            exp_last_q.push_back(s_axis_tlast);
            md_open = !s_axis_tlast;
            if (first_acc < 0) first_acc = cyc;
        end
        if (weight_load) begin
            md_pend = weight_in;
            md_pend_v = 1'b1;
        end
        @(posedge CLK);
        #1;
        cyc++;
        weight_load = 1'b0;
        check("weight_active", 256'(weight_active), 256'(md_active));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_w(input logic [7:0] w);
        weight_in = w;
        weight_load = 1'b1;
    endtask

    task automatic send_beat(input logic [127:0] d, input bit last);
        int guard = 0;
        s_axis_tdata = d;
        s_axis_tlast = last;
        s_axis_tvalid = 1'b1;
        do begin
            cycle();
            guard++;
        end while (!last_acc && guard < 200);
        if (!last_acc) fail_now("input_accept_timeout");
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tlast = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() > 0 || m_axis_tvalid) && guard < 1000) begin
            cycle();
            guard++;
        end
        if (exp_q.size() > 0) fail_now("drain_timeout");
    endtask

    function automatic logic [127:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        vecs[0] = '{8'h02, 8'h7F, 16'h00FE};
        vecs[1] = '{8'h02, 8'h80, 16'hFF00};
        vecs[2] = '{8'h02, 8'h00, 16'h0000};
        vecs[3] = '{8'h02, 8'hFF, 16'hFFFE};
        vecs[4] = '{8'h80, 8'h80, 16'h4000};
        vecs[5] = '{8'h7F, 8'h80, 16'hC080};
        vecs[6] = '{8'hFF, 8'h80, 16'h0080};
        vecs[7] = '{8'h80, 8'h7F, 16'hC080};

        // Reset state
        #12;
        check("rst_valid", 256'(m_axis_tvalid), 256'h0);
        check("rst_tready", 256'(s_axis_tready), 256'h0);
        check("rst_weight", 256'(weight_active), 256'(8'h01));
        @(negedge CLK);
        resetn = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_tready", 256'(s_axis_tready), 256'h1);

        // Idle apply
        load_w(8'h04);
        idle(2);
        check("idle_apply_04", 256'(weight_active), 256'(8'h04));

        // Arithmetic vectors
        foreach (vecs[k]) begin
            logic [255:0] expv;
            load_w(vecs[k].w);
            idle(2);
            send_beat({16{vecs[k].s}}, 1'b1);
            drain();
            expv = {16{vecs[k].p}};
            check("math_vec", last_out, expv);
        end

        // Back-to-back streaming
        load_w(8'h03);
        idle(2);
        first_acc = -1; first_out = -1; out_n = 0; last_cnt = 0; last_idx = 0;
        for (int b = 1; b <= 64; b++) send_beat(rand_data(), b == 64);
        drain();
        check("stream_latency", 256'(first_out - first_acc), 256'(2));
        check("stream_count", 256'(out_n), 256'(64));
        check("stream_contig", 256'(last_out_cyc - first_out + 1), 256'(64));
        check("stream_last_cnt", 256'(last_cnt), 256'(1));
        check("stream_last_idx", 256'(last_idx), 256'(64));

        // Weight load mid-packet
        load_w(8'h11);
        idle(2);
        for (int b = 1; b <= 8; b++) begin
            if (b == 3) load_w(8'h03);
            send_beat({16{8'h01}}, b == 8);
            if (b == 5) check("frozen_in_pkt", 256'(weight_active), 256'(8'h11));
        end
        drain();
        check("pkt1_old_weight", last_out, {16{16'h0011}});
        send_beat({16{8'h01}}, 1'b0);
        send_beat({16{8'h01}}, 1'b1);
        drain();
        check("pkt2_new_weight", last_out, {16{16'h0003}});
        for (int b = 1; b <= 4; b++) begin
            if (b == 2) load_w(8'h03);
            if (b == 3) load_w(8'h05);
            send_beat({16{8'h01}}, b == 4);
        end
        send_beat({16{8'h01}}, 1'b1);
        drain();
        check("double_load_05", last_out, {16{16'h0005}});
        check("double_load_active", 256'(weight_active), 256'(8'h05));

        // Random traffic with backpressure
        rdy_random = 1'b1;
        for (int p = 0; p < 30; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 1; b <= len; b++) begin
                if ($urandom_range(0, 4) == 0) load_w(8'($urandom()));
                send_beat(rand_data(), b == len);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        drain();
        rdy_random = 1'b0;
        idle(2);

        // Reset mid-stream
        load_w(8'h06);
        idle(2);
        for (int b = 0; b < 3; b++) send_beat(rand_data(), 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata = rand_data();
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", 256'(m_axis_tvalid), 256'h0);
        check("mid_rst_data", m_axis_tdata, 256'h0);
        check("mid_rst_keep", 256'(m_axis_tkeep), 256'h0);
        check("mid_rst_last", 256'(m_axis_tlast), 256'h0);
        check("mid_rst_tready", 256'(s_axis_tready), 256'h0);
        check("mid_rst_weight", 256'(weight_active), 256'(8'h01));
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        exp_q.delete();
        exp_last_q.delete();
        md_active = 8'h01; md_pend_v = 1'b0; md_open = 1'b0; stall_prev = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        resetn = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_post_tready", 256'(s_axis_tready), 256'h1);
        idle(4);
        send_beat({16{8'h7F}}, 1'b1);
        drain();
        check("post_rst_beat", last_out, {16{16'h007F}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
